// File: rtl/dut_ctrl_pkg.sv
// Shared constants for the dut access path.
//   - dut register map: addresses seen on write_address/read_address.
//   - Scheduler FSM state encodings.
package dut_ctrl_pkg;

    localparam logic [2:0] ADDR_A_WR   = 3'd0;
    localparam logic [2:0] ADDR_A_RD   = 3'd0;
    localparam logic [2:0] ADDR_B_RD   = 3'd1;
    localparam logic [2:0] ADDR_Y_STAT = 3'd2;
    localparam logic [2:0] ADDR_Y_DATA = 3'd3;
    localparam logic [2:0] ADDR_B_WR   = 3'd5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_POLL  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

endpackage

// File: rtl/dut_access_sched_rr_arbiter.sv
// Round-robin arbiter (combinational).
//   req   : request vector, one bit per requester
//   ptr   : highest-priority requester index this round
//   grant : one-hot grant, first set req bit at or after ptr with wrap; 0 if none
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dut_access_sched.sv
// Shares the dut's single write/read port between NUM_REQ requesters.
// One transaction per round-robin grant; read data is returned to the
// granted requester. Reads of the y result FIFO can first poll the status
// word until y holds data, giving up after POLL_LIMIT polls.
//   CLK, RST                      clock / async active-high reset
//   req_valid/ready/write/addr/wdata   requester side (per-requester slices)
//   rsp_valid/data/timeout        one-cycle completion to granted requester
//   write_en/address/data, write_rdy   dut write port
//   read_en/address, read_data, read_rdy dut read port
module dut_access_sched
    import dut_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int POLL_Y     = 1,
    parameter int POLL_LIMIT = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ-1:0]   req_write,
    input  logic [3*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_data,
    output logic                 rsp_timeout,
    output logic                 write_en,
    output logic [2:0]           write_address,
    output logic [7:0]           write_data,
    input  logic                 write_rdy,
    output logic                 read_en,
    output logic [2:0]           read_address,
    input  logic [7:0]           read_data,
    input  logic                 read_rdy
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(POLL_LIMIT) + 1;

    // Control state (reset)
    logic [1:0]         state;
    logic [PW-1:0]      rr_ptr;
    logic [CW-1:0]      poll_cnt;
    logic [NUM_REQ-1:0] gnt_q;
    logic               timeout_q;

    // Latched transaction and response data (not reset; only observed via state)
    logic               wr_q;
    logic [2:0]         addr_q;
    logic [7:0]         wdata_q;
    logic [7:0]         rsp_data_q;

    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      g_idx;
    logic               sel_wr;
    logic [2:0]         sel_addr;
    logic [7:0]         sel_wdata;
    logic               accept;
    logic               issue_fire;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    always_comb begin
        g_idx     = '0;
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                g_idx     = PW'(k);
                sel_wr    = req_write[k];
                sel_addr  = req_addr[3*k +: 3];
                sel_wdata = req_wdata[8*k +: 8];
            end
        end
    end

    assign accept     = (state == ST_IDLE) && (|req_valid);
    assign issue_fire = (state == ST_ISSUE) && (wr_q ? write_rdy : read_rdy);

    // Outputs decode registered state only (plus the handshake inputs from
    // dut); RST forces everything low, including the combinational req_ready.
    always_comb begin
        req_ready     = '0;
        rsp_valid     = '0;
        rsp_data      = '0;
        rsp_timeout   = 1'b0;
        write_en      = 1'b0;
        write_address = '0;
        write_data    = '0;
        read_en       = 1'b0;
        read_address  = '0;
        if (!RST) begin
            case (state)
                ST_IDLE:  req_ready = grant;
                ST_ISSUE: begin
                    if (wr_q) begin
                        write_address = addr_q;
                        write_data    = wdata_q;
                        write_en      = write_rdy;
                    end else begin
                        read_address  = addr_q;
                        read_en       = read_rdy;
                    end
                end
                // Status read has no side effect, so read_en stays low.
                ST_POLL:  read_address = ADDR_Y_STAT;
                default: begin
                    rsp_valid   = gnt_q;
                    rsp_timeout = timeout_q;
                    rsp_data    = rsp_data_q;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            poll_cnt  <= '0;
            gnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        gnt_q     <= grant;
                        rr_ptr    <= (int'(g_idx) == NUM_REQ - 1) ? '0 : g_idx + 1'b1;
                        poll_cnt  <= '0;
                        timeout_q <= 1'b0;
                        if (!sel_wr && sel_addr == ADDR_Y_DATA && POLL_Y != 0)
                            state <= ST_POLL;
                        else
                            state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue_fire)
                        state <= ST_RESP;
                end
                ST_POLL: begin
                    if (read_data[0]) begin
                        state <= ST_ISSUE;
                    end else if (poll_cnt == CW'(POLL_LIMIT - 1)) begin
                        state     <= ST_RESP;
                        timeout_q <= 1'b1;
                    end else begin
                        poll_cnt <= poll_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            wr_q    <= sel_wr;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end
        if (issue_fire)
            rsp_data_q <= wr_q ? 8'h00 : read_data;
        else if (state == ST_POLL && !read_data[0])
            rsp_data_q <= 8'h00;
    end

endmodule

// File: tb/tb_dut_access_sched.sv
module tb_dut_access_sched;

    localparam int NR  = 2;
    localparam int LIM = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
    logic [5:0]  req_addr;
    logic [15:0] req_wdata;
    logic [7:0]  rsp_data, write_data, read_data;
    logic        rsp_timeout, write_en, write_rdy, read_en, read_rdy;
    logic [2:0]  write_address, read_address;

    always #5 CLK = ~CLK;

    dut_access_sched #(.NUM_REQ(NR), .POLL_Y(1), .POLL_LIMIT(LIM)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .write_en(write_en), .write_address(write_address), .write_data(write_data),
        .write_rdy(write_rdy),
        .read_en(read_en), .read_address(read_address), .read_data(read_data),
        .read_rdy(read_rdy)
    );

    // Small behavioural stand-in for dut: a at addr0, b at addr5,
    // y = a|b appears at a bench-chosen cycle, status bit0 = y present.
    logic [7:0] a_ff = 8'h00, b_ff = 8'h00, y_data = 8'h00;
    logic       y_valid = 1'b0;
    int         cyc = 0;
    int         y_ready_at = -1;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (write_en && write_address == 3'd0) a_ff <= write_data;
        if (write_en && write_address == 3'd5) b_ff <= write_data;
        if (cyc == y_ready_at) begin
            y_valid <= 1'b1;
            y_data  <= a_ff | b_ff;
        end else if (read_en && read_address == 3'd3) begin
            y_valid <= 1'b0;
        end
    end

    always_comb begin
        case (read_address)
            3'd0:    read_data = a_ff;
            3'd1:    read_data = b_ff;
            3'd2:    read_data = {7'b0, y_valid};
            3'd3:    read_data = y_data;
            default: read_data = 8'h00;
        endcase
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct { int idx; logic [7:0] data; logic to; } rsp_t;
    typedef struct { logic [2:0] a; logic [7:0] d; } wr_t;
    rsp_t sbq[$];
    wr_t  wq[$];
    int   grants[$];

    logic [7:0] e_d[NR];
    logic       e_to[NR];

    int poll_cycles = 0;
    int y_reads     = 0;
    int wen_cnt     = 0;

    // Monitor: pops expected responses / writes whenever dut presents them.
    always @(negedge CLK) begin
        if (!RST) begin
            if (write_en && read_en) chk("wr_rd_overlap", 32'(read_en), 32'(0));
            if (read_address == 3'd2 && !read_en) poll_cycles++;
            if (read_en && read_address == 3'd3) y_reads++;
            if (|rsp_valid) begin
                if (sbq.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'(0));
                end else begin
                    rsp_t e;
                    e = sbq.pop_front();
                    chk("rsp_valid", 32'(rsp_valid), 32'(2'b01 << e.idx));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                end
            end
            if (write_en) begin
                wen_cnt++;
                if (wq.size() == 0) begin
                    chk("write_unexpected", 32'(write_en), 32'(0));
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("write_address", 32'(write_address), 32'(w.a));
                    chk("write_data", 32'(write_data), 32'(w.d));
                end
            end
        end
    end

    task automatic set_req(input int i, input logic wr, input logic [2:0] a,
                           input logic [7:0] d, input logic [7:0] ed, input logic eto);
        req_write[i]       = wr;
        req_addr[3*i +: 3] = a;
        req_wdata[8*i +: 8] = d;
        e_d[i]             = ed;
        e_to[i]            = eto;
        req_valid[i]       = 1'b1;
    endtask

    task automatic note_accept(input int i);
        rsp_t r;
        wr_t  w;
        r.idx = i; r.data = e_d[i]; r.to = e_to[i];
        sbq.push_back(r);
        if (req_write[i]) begin
            w.a = req_addr[3*i +: 3];
            w.d = req_wdata[8*i +: 8];
            wq.push_back(w);
        end
        grants.push_back(i);
    endtask

    // Called at a negedge; returns at a negedge once every request is accepted.
    task automatic run_reqs(input int budget);
        logic [1:0] clr;
        clr = 2'b00;
        for (int c = 0; c < budget && req_valid != 2'b00; c++) begin
            #1;
            for (int i = 0; i < NR; i++)
                if (req_ready[i]) begin
                    note_accept(i);
                    clr[i] = 1'b1;
                end
            @(negedge CLK);
            req_valid = req_valid & ~clr;
            clr = 2'b00;
        end
        chk("accept_timeout", 32'(req_valid), 32'(0));
        req_valid = 2'b00;
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && (sbq.size() != 0 || wq.size() != 0); c++)
            @(negedge CLK);
        chk("drain_rsp", 32'(sbq.size()), 32'(0));
        chk("drain_wr", 32'(wq.size()), 32'(0));
        @(negedge CLK);
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, 32'({req_ready, rsp_valid, rsp_data, rsp_timeout, write_en,
                     write_address, write_data, read_en, read_address}), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        write_rdy = 1'b1; read_rdy = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        chk_all_zero("reset_outputs");
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Reset while polling an empty y.
        set_req(0, 1'b0, 3'd3, 8'h00, 8'h00, 1'b0);
        run_reqs(10);
        @(negedge CLK);
        RST = 1'b1;
        // Requests pending during reset must not see req_ready.
        set_req(0, 1'b1, 3'd0, 8'h5A, 8'h00, 1'b0);
        set_req(1, 1'b1, 3'd5, 8'h0F, 8'h00, 1'b0);
        #1;
        chk_all_zero("reset_midpoll_outputs");
        sbq.delete();
        grants.delete();
        @(negedge CLK);
        #1;
        chk("reset_hold_rsp", 32'(rsp_valid), 32'(0));
        @(negedge CLK);
        RST = 1'b0;

        // Simultaneous writes: R0 first after reset, then R1.
        run_reqs(20);
        drain(20);
        chk("t2_grant0", 32'(grants[0]), 32'(0));
        chk("t2_grant1", 32'(grants[1]), 32'(1));
        grants.delete();

        // R1 reads y: status comes up after a few polls, y = 5A|0F.
        poll_cycles = 0; y_reads = 0;
        y_ready_at  = cyc + 2;
        set_req(1, 1'b0, 3'd3, 8'h00, 8'h5F, 1'b0);
        run_reqs(10);
        drain(20);
        chk("t3_polls", 32'(poll_cycles), 32'(3));
        chk("t3_yreads", 32'(y_reads), 32'(1));

        // R0 reads empty y: exactly LIM polls then timeout, no pop.
        poll_cycles = 0; y_reads = 0;
        set_req(0, 1'b0, 3'd3, 8'h00, 8'h00, 1'b1);
        run_reqs(10);
        drain(20);
        chk("t4_polls", 32'(poll_cycles), 32'(LIM));
        chk("t4_yreads", 32'(y_reads), 32'(0));

        // Write to an upper address is forwarded unchanged; leaves rr_ptr at 0.
        set_req(1, 1'b1, 3'd6, 8'h77, 8'h00, 1'b0);
        run_reqs(10);
        drain(20);

        // Both requesters continuously requesting: strict alternation.
        set_req(0, 1'b0, 3'd1, 8'h00, 8'h0F, 1'b0);
        set_req(1, 1'b0, 3'd7, 8'h00, 8'h00, 1'b0);
        grants.delete();
        for (int n = 0, c = 0; n < 12 && c < 100; c++) begin
            #1;
            for (int i = 0; i < NR; i++)
                if (req_ready[i]) begin
                    note_accept(i);
                    chk("t5_grant_order", 32'(i), 32'(n % 2));
                    n++;
                end
            @(negedge CLK);
        end
        req_valid = 2'b00;
        chk("t5_grant_count", 32'(grants.size()), 32'(12));
        drain(20);

        // Write stalled by write_rdy=0 for 5 cycles.
        write_rdy = 1'b0;
        wen_cnt = 0;
        set_req(0, 1'b1, 3'd0, 8'hC3, 8'h00, 1'b0);
        run_reqs(10);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t6_stall_wen", 32'(write_en), 32'(0));
            @(negedge CLK);
        end
        write_rdy = 1'b1;
        drain(20);
        chk("t6_wen_pulses", 32'(wen_cnt), 32'(1));
        chk("t6_a_ff", 32'(a_ff), 32'(8'hC3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
